line_buffer_taps: RTL and testbench

//  Parametrised line buffer for the edge-detector datapath; successor to the fixed 32-bit shift_32 store.

---
 rtl/line_buffer_taps.sv | 94 +++++++++
 tb/tb_line_buffer_taps.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_taps.sv
// Line buffer for the edge-detector datapath: stores TAPS-1 previous lines of a raster
// stream and emits one vertical TAPS-pixel column per accepted pixel once primed.
module line_buffer_taps #(
    parameter int DATA_W   = 32,
    parameter int LINE_LEN = 71,
    parameter int TAPS     = 3,
    localparam int COL_W   = $clog2(LINE_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAPS*DATA_W-1:0] out_taps,
    output logic [COL_W-1:0]       out_col,
    output logic                   out_eol
);

    localparam int ROW_W = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0] FULL_ROWS = ROW_W'(TAPS - 1);

    // Line stores: mem[0] holds the previous line, mem[TAPS-2] the oldest one.
    logic [DATA_W-1:0] mem [TAPS-1][LINE_LEN];

    logic [COL_W-1:0]       wr_ptr;
    logic [ROW_W-1:0]       rows_filled;
    logic [TAPS*DATA_W-1:0] column;
    logic                   accept;
    logic                   at_eol;
    logic                   primed;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is low during flush and while a column waits in the output register;
    // out_valid/out_taps/out_col/out_eol stay stable until out_ready takes the column.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign at_eol   = (wr_ptr == LAST_COL);
    assign primed   = (rows_filled == FULL_ROWS);

    // Column is read from the stores before this pixel's write lands.
    always_comb begin
        column              = '0;
        column[DATA_W-1:0]  = in_data;
        for (int k = 0; k < TAPS - 1; k++) begin
            column[(k+1)*DATA_W +: DATA_W] = mem[k][wr_ptr];
        end
    end

    // RAM contents are deliberately not reset; priming guarantees they are rewritten first.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[0][wr_ptr] <= in_data;
            for (int k = 1; k < TAPS - 1; k++) begin
                mem[k][wr_ptr] <= mem[k-1][wr_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rows_filled <= '0;
            out_valid   <= 1'b0;
            out_taps    <= '0;
            out_col     <= '0;
            out_eol     <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rows_filled <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                wr_ptr <= at_eol ? '0 : wr_ptr + COL_W'(1);
                if (at_eol && !primed) begin
                    rows_filled <= rows_filled + ROW_W'(1);
                end
                if (primed) begin
                    out_valid <= 1'b1;
                    out_taps  <= column;
                    out_col   <= wr_ptr;
                    out_eol   <= at_eol;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed and randomized-handshake bench for line_buffer_taps at DATA_W=8, LINE_LEN=4, TAPS=3.
module tb_line_buffer_taps;

    localparam int DW = 8;
    localparam int LL = 4;
    localparam int TP = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [TP*DW-1:0] out_taps;
    logic [CW-1:0] out_col;
    logic          out_eol;

    int n_tests = 0;
    int n_fail  = 0;

    logic [TP*DW+CW:0] exp_q[$];

    line_buffer_taps #(.DATA_W(DW), .LINE_LEN(LL), .TAPS(TP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taps(out_taps), .out_col(out_col), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    // Called just after a falling edge: applies inputs, notes whether the transfer
    // will happen, then returns after the next falling edge with outputs settled.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        acc = v & in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({out_valid, out_taps, out_col, out_eol} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_taps, out_col, out_eol});
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_priming;
        logic acc;
        for (int p = 0; p < 8; p++) begin
            step(1'b1, DW'(p), 1'b1, 1'b0, acc);
            n_tests++;
            if ({acc, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL priming_px%0d: acc/out_valid got %b want 10", p, {acc, out_valid});
            end
        end
        step(1'b1, 8'd8, 1'b1, 1'b0, acc);
        n_tests++;
        if ({out_valid, out_taps, out_col, out_eol} !== {1'b1, 8'd0, 8'd4, 8'd8, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL priming_first_col: got %h want %h", {out_valid, out_taps, out_col, out_eol},
                     {1'b1, 8'd0, 8'd4, 8'd8, 2'd0, 1'b0});
        end
    endtask

    task automatic test_back_to_back;
        logic acc;
        logic [TP*DW+CW+1:0] exp_t [7];
        exp_t[0] = {1'b1, 8'd1, 8'd5,  8'd9,  2'd1, 1'b0};
        exp_t[1] = {1'b1, 8'd2, 8'd6,  8'd10, 2'd2, 1'b0};
        exp_t[2] = {1'b1, 8'd3, 8'd7,  8'd11, 2'd3, 1'b1};
        exp_t[3] = {1'b1, 8'd4, 8'd8,  8'd12, 2'd0, 1'b0};
        exp_t[4] = {1'b1, 8'd5, 8'd9,  8'd13, 2'd1, 1'b0};
        exp_t[5] = {1'b1, 8'd6, 8'd10, 8'd14, 2'd2, 1'b0};
        exp_t[6] = {1'b1, 8'd7, 8'd11, 8'd15, 2'd3, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, DW'(9 + i), 1'b1, 1'b0, acc);
            n_tests++;
            if ({out_valid, out_taps, out_col, out_eol} !== exp_t[i] || acc !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_px%0d: got %h acc %b want %h acc 1", 9 + i,
                         {out_valid, out_taps, out_col, out_eol}, acc, exp_t[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic acc;
        step(1'b0, 8'd0, 1'b1, 1'b1, acc);
        for (int p = 0; p < 10; p++) step(1'b1, DW'(p), 1'b1, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd10, 1'b0, 1'b0, acc);
            n_tests++;
            if ({acc, out_valid, out_taps, out_col, out_eol} !==
                {1'b0, 1'b1, 8'd1, 8'd5, 8'd9, 2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h want %h", i,
                         {acc, out_valid, out_taps, out_col, out_eol},
                         {1'b0, 1'b1, 8'd1, 8'd5, 8'd9, 2'd1, 1'b0});
            end
        end
        step(1'b1, 8'd10, 1'b1, 1'b0, acc);
        n_tests++;
        if ({acc, out_valid, out_taps, out_col, out_eol} !==
            {1'b1, 1'b1, 8'd2, 8'd6, 8'd10, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_release: got %h want %h",
                     {acc, out_valid, out_taps, out_col, out_eol},
                     {1'b1, 1'b1, 8'd2, 8'd6, 8'd10, 2'd2, 1'b0});
        end
    endtask

    task automatic test_flush;
        logic acc;
        step(1'b1, 8'd11, 1'b1, 1'b0, acc);
        n_tests++;
        if ({out_valid, out_taps, out_col, out_eol} !== {1'b1, 8'd3, 8'd7, 8'd11, 2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_pre_eol: got %h want %h", {out_valid, out_taps, out_col, out_eol},
                     {1'b1, 8'd3, 8'd7, 8'd11, 2'd3, 1'b1});
        end
        step(1'b1, 8'd12, 1'b1, 1'b0, acc);
        step(1'b1, 8'd13, 1'b1, 1'b1, acc);
        n_tests++;
        if ({acc, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_cycle: acc/out_valid got %b want 00", {acc, out_valid});
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(13 + i), 1'b1, 1'b0, acc);
            n_tests++;
            if ({acc, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL flush_reprime_%0d: acc/out_valid got %b want 10", i, {acc, out_valid});
            end
        end
        step(1'b1, 8'd21, 1'b1, 1'b0, acc);
        n_tests++;
        if ({out_valid, out_taps, out_col, out_eol} !== {1'b1, 8'd13, 8'd17, 8'd21, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_first_col: got %h want %h", {out_valid, out_taps, out_col, out_eol},
                     {1'b1, 8'd13, 8'd17, 8'd21, 2'd0, 1'b0});
        end
    endtask

    task automatic test_async_reset;
        logic acc;
        step(1'b1, 8'd22, 1'b1, 1'b0, acc);
        step(1'b1, 8'd23, 1'b0, 1'b0, acc);
        n_tests++;
        if ({acc, out_valid, out_taps, out_col, out_eol} !==
            {1'b0, 1'b1, 8'd14, 8'd18, 8'd22, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_pre_stall: got %h want %h",
                     {acc, out_valid, out_taps, out_col, out_eol},
                     {1'b0, 1'b1, 8'd14, 8'd18, 8'd22, 2'd1, 1'b0});
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_taps, out_col, out_eol} !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h want 0", {out_valid, out_taps, out_col, out_eol});
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        test_priming();
    endtask

    task automatic test_random;
        logic acc;
        logic pending;
        int   sent;
        logic [DW-1:0] a, b, c;
        logic [TP*DW+CW:0] e;
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);
        exp_q.delete();
        pending = 1'b0;
        sent    = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            if (!pending) pending = ($urandom_range(0, 1) == 1);
            in_valid  = pending;
            in_data   = DW'(sent);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected_col: got %h with no column pending",
                             {out_taps, out_col, out_eol});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_taps, out_col, out_eol} !== e) begin
                        n_fail++;
                        $display("FAIL rand_col: got %h want %h", {out_taps, out_col, out_eol}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (sent >= 8) begin
                    a = DW'(sent - 8);
                    b = DW'(sent - 4);
                    c = DW'(sent);
                    exp_q.push_back({a, b, c, CW'(sent % LL), (sent % LL) == LL - 1});
                end
                sent++;
                pending = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (sent != 1000) begin
            n_fail++;
            $display("FAIL rand_timeout: sent %0d want 1000", sent);
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) begin
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_tests++;
                e = exp_q.pop_front();
                if ({out_taps, out_col, out_eol} !== e) begin
                    n_fail++;
                    $display("FAIL rand_drain_col: got %h want %h", {out_taps, out_col, out_eol}, e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: left %0d out_valid %b want 0 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_priming();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
